id_stage_piped: RTL and testbench
=================================

# id_stage_piped

Registered, parametrised RV32I/RV64I decode stage. Sits between IF and EX, and replaces the purely combinational decoder with an ID/EX pipeline register that uses valid/ready handshakes. It adds:
- load-use interlock with bubble insertion;
- EX/MEM operand forwarding;
- branch/jump resolution in ID with a one-cycle redirect pulse and wrong-path squash;
- a saturating bubble counter.

## Interface
Parameters:
- XLEN, 32: data/PC width; legal values 32 or 64.
- CNT_W, 16: width of the bubble counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- if_valid_i  in  1  IF presents pc_i/inst_i.
- id_ready_o  out  1  ID accepts this cycle.
- pc_i  in  XLEN  instruction PC.
- inst_i  in  32  instruction word.
- reg1_addr_o, reg2_addr_o  out  5  regfile read addresses (rs1, rs2), combinational from inst_i.
- reg1_data_i, reg2_data_i  in  XLEN  regfile read data, same cycle.
- ex_op_i  in  7  opcode in EX.
- ex_wreg_i  in  1  EX writes a register.
- ex_wd_i  in  5  EX destination register.
- ex_wdata_i  in  XLEN  EX result.
- mem_wreg_i  in  1  MEM writes a register.
- mem_wd_i  in  5  MEM destination register.
- mem_wdata_i  in  XLEN  MEM result.
- flush_i  in  1  later-stage flush; kills the ID/EX register and the current input.
- ex_ready_i  in  1  EX accepts.
- ex_valid_o  out  1  ID/EX register holds a valid instruction.
- pc_o, reg1_o, reg2_o, imm_o  out  XLEN  registered PC, operands, immediate.
- op_o  out  7  registered opcode.
- funct3_o  out  3  registered funct3.
- funct7_o  out  1  registered inst[30].
- wd_o  out  5  registered destination register.
- wreg_o  out  1  registered write enable.
- illegal_o  out  1  registered; opcode not in the decoded set.
- branch_flag_o  out  1  registered one-cycle redirect pulse.
- branch_address_o  out  XLEN  redirect target, valid while branch_flag_o is high.
- bubble_cnt_o  out  CNT_W  saturating count of load-use bubbles.

## Operation
- **Decoded opcodes:** LUI, AUIPC, LOAD, STORE, OP-IMM, OP, BRANCH, JAL, JALR.
- **Other opcodes:** the instruction still issues with wreg_o=0 and illegal_o=1.
- **Immediates:** I/S/B/U/J immediates are sign-extended to XLEN.
- **OP-IMM shifts:** shamt is zero-extended. It is inst[24:20] when XLEN=32 and inst[25:20] when XLEN=64.
- **Source read enables:**
  - rs1 is read for LOAD, STORE, OP-IMM, OP, BRANCH, JALR.
  - rs2 is read for STORE, OP, BRANCH.
- **Operand select, priority highest first:**
  1. Address 0 gives 0.
  2. EX forward, when ex_wreg_i and ex_wd_i matches.
  3. MEM forward, when mem_wreg_i and mem_wd_i matches.
  4. Regfile data.
  5. If the source is not read, the operand is 0.
- **Load-use hazard:** asserted when ex_valid_o && ex_op_i==LOAD && ex_wreg_i && ex_wd_i!=0 && ex_wd_i matches a read source. While the hazard is asserted, id_ready_o=0.
- **Ready:** id_ready_o = !hazard && (!ex_valid_o || ex_ready_i).
- **ID/EX register update, priority highest first:**
  1. flush_i: ex_valid_o <= 0.
  2. Accept (if_valid_i && id_ready_o && !squash): load all outputs and set ex_valid_o <= 1.
  3. Otherwise, if ex_ready_i: ex_valid_o <= 0. This is the bubble.
  4. Otherwise: hold.
- **Bubble counter:** bubble_cnt_o increments when the hazard is asserted && ex_ready_i && !flush_i. It saturates at all-ones.
- **Branch conditions:** BEQ ==, BNE !=, BLT signed <, BGE signed >=, BLTU unsigned <, BGEU unsigned >=. Other funct3 values mean not taken.
- **Targets:** branch/JAL target = pc_i+imm. JALR target = (rs1+imm) & ~1. Arithmetic is modulo 2^XLEN.
- **Redirect:** on accepting a taken branch or any jump, and without flush_i, branch_flag_o <= 1 next cycle and branch_address_o <= target. Otherwise branch_flag_o <= 0.
- **Squash:** squash = branch_flag_o. In that cycle id_ready_o is unchanged, and an input that would otherwise be accepted is consumed and discarded (wrong path). ex_valid_o follows rule 3 or 4.
- **Flush and redirect together:** when flush_i coincides with branch_flag_o, flush wins and squash still applies.

## Timing
- Reset values: all outputs 0, ex_valid_o=0, bubble_cnt_o=0. Reset is asynchronous and takes effect immediately, including mid-stall and mid-redirect.
- Decode latency is 1 cycle, input accept to ex_valid_o.
- The redirect pulse appears in the same cycle that the branch is visible on the ID/EX outputs.
- A load-use stall costs exactly 1 bubble when ex_ready_i=1, and more bubbles while ex_ready_i=0.
- The forwarding, hazard and ready paths are combinational. branch_flag_o is registered.

## Configuration
- Macro: ID_BRANCH_RESOLVE_EN.
- Defined: branch and jump resolution in ID as described above.
- Undefined:
  - branch_flag_o and branch_address_o are tied to 0 and squash is never asserted;
  - branches and jumps issue normally, with targets left to EX;
  - the comparators and target adders are not built.

## Test plan
- Reset asserted mid-stream with ex_valid_o=1 → all outputs 0 asynchronously; after release, the first accepted ADDI x1,x0,5 gives ex_valid_o=1, imm_o=5, reg1_o=0, wd_o=1.
- EX holds LW x3 and ID has ADD x4,x3,x2 → id_ready_o=0 for 1 cycle, then ex_valid_o=0 (bubble) and bubble_cnt_o=1; the next cycle the ADD issues with reg1_o=mem_wdata_i.
- EX writes x5=0xAA and MEM writes x5=0xBB; ID has SUB x6,x5,x5 → reg1_o=reg2_o=0xAA. A write to x0 from EX is never forwarded.
- BEQ at pc 0x100 with imm=-8 and equal operands → branch_flag_o pulses 1 cycle, branch_address_o=0xF8, and the input presented in that cycle is dropped. BGE with equal operands is also taken.
- JALR with rs1=0x1003 and imm=0 → target 0x1002. flush_i in the accept cycle → ex_valid_o=0 and no pulse.
- ex_ready_i=0 for 3 cycles with a valid instruction held in ID/EX → all outputs are stable and id_ready_o=0. Driving bubble_cnt_o to saturation with CNT_W=2 → it holds 3.

Source files
------------

// File: rtl/id_stage_piped.sv
// Registered RV32I/RV64I decode stage: ID/EX register with valid/ready handshake, load-use
// interlock, EX/MEM forwarding, saturating bubble counter. ID_BRANCH_RESOLVE_EN adds ID-side redirect.
module id_stage_piped #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid_i,
  output logic             id_ready_o,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [31:0]      inst_i,
  output logic [4:0]       reg1_addr_o,
  output logic [4:0]       reg2_addr_o,
  input  logic [XLEN-1:0]  reg1_data_i,
  input  logic [XLEN-1:0]  reg2_data_i,
  input  logic [6:0]       ex_op_i,
  input  logic             ex_wreg_i,
  input  logic [4:0]       ex_wd_i,
  input  logic [XLEN-1:0]  ex_wdata_i,
  input  logic             mem_wreg_i,
  input  logic [4:0]       mem_wd_i,
  input  logic [XLEN-1:0]  mem_wdata_i,
  input  logic             flush_i,
  input  logic             ex_ready_i,
  output logic             ex_valid_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  reg1_o,
  output logic [XLEN-1:0]  reg2_o,
  output logic [XLEN-1:0]  imm_o,
  output logic [6:0]       op_o,
  output logic [2:0]       funct3_o,
  output logic             funct7_o,
  output logic [4:0]       wd_o,
  output logic             wreg_o,
  output logic             illegal_o,
  output logic             branch_flag_o,
  output logic [XLEN-1:0]  branch_address_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [6:0] opcode;
  logic [4:0] rs1, rs2, rd;
  logic [2:0] funct3;

  assign opcode      = inst_i[6:0];
  assign rd          = inst_i[11:7];
  assign funct3      = inst_i[14:12];
  assign rs1         = inst_i[19:15];
  assign rs2         = inst_i[24:20];
  assign reg1_addr_o = rs1;
  assign reg2_addr_o = rs2;

  logic               legal, wreg, rs1_re, rs2_re;
  logic signed [31:0] imm32;
  logic [31:0]        shamt;
  logic [XLEN-1:0]    imm;

  assign shamt = (XLEN == 64) ? {26'b0, inst_i[25:20]} : {27'b0, inst_i[24:20]};

  always_comb begin
    legal  = 1'b0;
    wreg   = 1'b0;
    rs1_re = 1'b0;
    rs2_re = 1'b0;
    imm32  = '0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        legal = 1'b1; wreg = 1'b1;
        imm32 = {inst_i[31:12], 12'b0};
      end
      OP_LOAD, OP_JALR: begin
        legal = 1'b1; wreg = 1'b1; rs1_re = 1'b1;
        imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      end
      OP_STORE: begin
        legal = 1'b1; rs1_re = 1'b1; rs2_re = 1'b1;
        imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      end
      OP_IMM: begin
        legal = 1'b1; wreg = 1'b1; rs1_re = 1'b1;
        // SLLI/SRLI/SRAI carry a zero-extended shamt; inst[30] goes out on funct7_o
        imm32 = (funct3[1:0] == 2'b01) ? shamt : {{20{inst_i[31]}}, inst_i[31:20]};
      end
      OP_OP: begin
        legal = 1'b1; wreg = 1'b1; rs1_re = 1'b1; rs2_re = 1'b1;
      end
      OP_BRANCH: begin
        legal = 1'b1; rs1_re = 1'b1; rs2_re = 1'b1;
        imm32 = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      end
      OP_JAL: begin
        legal = 1'b1; wreg = 1'b1;
        imm32 = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  assign imm = XLEN'(imm32);

  function automatic logic [XLEN-1:0] operand(
    input logic [4:0] addr, input logic re, input logic [XLEN-1:0] rf,
    input logic ew, input logic [4:0] ewd, input logic [XLEN-1:0] ewdata,
    input logic mw, input logic [4:0] mwd, input logic [XLEN-1:0] mwdata);
    if (!re || addr == 5'd0)   return '0;
    else if (ew && ewd == addr) return ewdata;
    else if (mw && mwd == addr) return mwdata;
    else                        return rf;
  endfunction

  logic [XLEN-1:0] op1, op2;
  assign op1 = operand(rs1, rs1_re, reg1_data_i, ex_wreg_i, ex_wd_i, ex_wdata_i,
                       mem_wreg_i, mem_wd_i, mem_wdata_i);
  assign op2 = operand(rs2, rs2_re, reg2_data_i, ex_wreg_i, ex_wd_i, ex_wdata_i,
                       mem_wreg_i, mem_wd_i, mem_wdata_i);

  logic hazard, squash, accept;
  assign hazard = ex_valid_o && (ex_op_i == OP_LOAD) && ex_wreg_i && (ex_wd_i != 5'd0) &&
                  ((rs1_re && ex_wd_i == rs1) || (rs2_re && ex_wd_i == rs2));
  assign id_ready_o = !hazard && (!ex_valid_o || ex_ready_i);
  // A live redirect means the instruction on the input is wrong-path: consume and drop it
  assign accept = if_valid_i && id_ready_o && !squash;

`ifdef ID_BRANCH_RESOLVE_EN
  logic            taken;
  logic [XLEN-1:0] target;

  always_comb begin
    taken  = 1'b0;
    target = pc_i + imm;
    case (opcode)
      OP_BRANCH: begin
        case (funct3)
          3'b000:  taken = (op1 == op2);
          3'b001:  taken = (op1 != op2);
          3'b100:  taken = ($signed(op1) <  $signed(op2));
          3'b101:  taken = ($signed(op1) >= $signed(op2));
          3'b110:  taken = (op1 <  op2);
          3'b111:  taken = (op1 >= op2);
          default: taken = 1'b0;
        endcase
      end
      OP_JAL:  taken = 1'b1;
      OP_JALR: begin
        taken  = 1'b1;
        target = (op1 + imm) & {{(XLEN-1){1'b1}}, 1'b0};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_flag_o    <= 1'b0;
      branch_address_o <= '0;
    end else begin
      branch_flag_o <= accept && !flush_i && taken;
      if (accept && !flush_i && taken) branch_address_o <= target;
    end
  end

  assign squash = branch_flag_o;
`else
  assign branch_flag_o    = 1'b0;
  assign branch_address_o = '0;
  assign squash           = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_o <= 1'b0;
      pc_o       <= '0;
      reg1_o     <= '0;
      reg2_o     <= '0;
      imm_o      <= '0;
      op_o       <= '0;
      funct3_o   <= '0;
      funct7_o   <= 1'b0;
      wd_o       <= '0;
      wreg_o     <= 1'b0;
      illegal_o  <= 1'b0;
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
    end else if (accept) begin
      ex_valid_o <= 1'b1;
      pc_o       <= pc_i;
      reg1_o     <= op1;
      reg2_o     <= op2;
      imm_o      <= imm;
      op_o       <= opcode;
      funct3_o   <= funct3;
      funct7_o   <= inst_i[30];
      wd_o       <= rd;
      wreg_o     <= wreg;
      illegal_o  <= !legal;
    end else if (ex_ready_i) begin
      ex_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bubble_cnt_o <= '0;
    else if (hazard && ex_ready_i && !flush_i && !(&bubble_cnt_o))
      bubble_cnt_o <= bubble_cnt_o + 1'b1;
  end

endmodule

// File: tb/tb_id_stage_piped.sv
// Scoreboard bench for id_stage_piped: a spec-level model predicts per-cycle handshake status
// and every issued ID/EX payload; a negedge monitor pops and compares against the DUT.
module tb_id_stage_piped;
  localparam int XLEN    = 32;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, LOAD = 7'h03, STORE = 7'h23, OPIMM = 7'h13,
                         OP = 7'h33, BR = 7'h63, JAL = 7'h6F, JALR = 7'h67;
`ifdef ID_BRANCH_RESOLVE_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic if_valid_i, id_ready_o, ex_wreg_i, mem_wreg_i, flush_i, ex_ready_i, ex_valid_o;
  logic [31:0] pc_i, inst_i, reg1_data_i, reg2_data_i, ex_wdata_i, mem_wdata_i;
  logic [4:0]  reg1_addr_o, reg2_addr_o, ex_wd_i, mem_wd_i, wd_o;
  logic [6:0]  ex_op_i, op_o;
  logic [31:0] pc_o, reg1_o, reg2_o, imm_o, branch_address_o;
  logic [2:0]  funct3_o;
  logic        funct7_o, wreg_o, illegal_o, branch_flag_o;
  logic [CNT_W-1:0] bubble_cnt_o;

  always #5 clk = ~clk;

  id_stage_piped #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .if_valid_i(if_valid_i), .id_ready_o(id_ready_o), .pc_i(pc_i),
    .inst_i(inst_i), .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i), .ex_op_i(ex_op_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .mem_wreg_i(mem_wreg_i),
    .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i), .flush_i(flush_i), .ex_ready_i(ex_ready_i),
    .ex_valid_o(ex_valid_o), .pc_o(pc_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .imm_o(imm_o),
    .op_o(op_o), .funct3_o(funct3_o), .funct7_o(funct7_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .illegal_o(illegal_o), .branch_flag_o(branch_flag_o), .branch_address_o(branch_address_o),
    .bubble_cnt_o(bubble_cnt_o));

  typedef struct {
    logic v; logic [31:0] inst, pc, r1, r2;
    logic [6:0] exop; logic exw; logic [4:0] exwd; logic [31:0] exd;
    logic mw; logic [4:0] mwd; logic [31:0] md; logic fl, rdy;
  } stim_t;
  typedef struct {
    logic rdy, valid, bflag; logic [31:0] baddr; logic [CNT_W-1:0] cnt; logic [4:0] a1, a2;
  } stat_t;
  typedef struct {
    logic [31:0] pc, r1, r2, imm; logic [6:0] op; logic [2:0] f3; logic f7;
    logic [4:0] wd; logic wreg, ill;
  } pay_t;

  stat_t sq[$];
  pay_t  pq[$];
  int checks = 0, errors = 0;
  logic m_valid = 1'b0, m_bflag = 1'b0;
  logic [31:0] m_baddr = '0;
  int m_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    return 32'($signed(v << (32 - bits)) >>> (32 - bits));
  endfunction

  function automatic logic [31:0] imm_of(input logic [31:0] i);
    case (i[6:0])
      LUI, AUIPC:  return i & 32'hFFFF_F000;
      LOAD, JALR:  return sext(i >> 20, 12);
      OPIMM:       return (i[13:12] == 2'b01) ? ((i >> 20) & 32'h1F) : sext(i >> 20, 12);
      STORE:       return sext(((i >> 25) << 5) | ((i >> 7) & 32'h1F), 12);
      BR:          return sext({19'b0, i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
      JAL:         return sext({11'b0, i[31], i[19:12], i[20], i[30:21], 1'b0}, 21);
      default:     return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] a, input logic used,
                                       input logic [31:0] rf, input stim_t s);
    if (!used || a == 0) return 32'h0;
    if (s.exw && s.exwd == a) return s.exd;
    if (s.mw && s.mwd == a) return s.md;
    return rf;
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) <  $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{v: 1'b0, inst: 32'h13, pc: 32'h0, r1: 32'h0, r2: 32'h0, exop: 7'h0, exw: 1'b0,
          exwd: 5'd0, exd: 32'h0, mw: 1'b0, mwd: 5'd0, md: 32'h0, fl: 1'b0, rdy: 1'b1};
    return s;
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [2:0] f3, input logic [4:0] rs1, input logic [11:0] im);
    return {im, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, OP};
  endfunction
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [12:0] im);
    return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], BR};
  endfunction

  function automatic logic [31:0] pickval();
    case ($urandom_range(0, 3))
      0: return 32'h0;
      1: return 32'($urandom_range(0, 3));
      2: return 32'h8000_0000 | 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    logic [6:0] ops [12] = '{LUI, AUIPC, LOAD, STORE, OPIMM, OP, BR, JAL, JALR, 7'h0F, 7'h73, 7'h00};
    s = idle();
    s.inst = $urandom;
    s.inst[6:0]   = ops[$urandom_range(0, 11)];
    s.inst[11:7]  = 5'($urandom_range(0, 7));
    s.inst[19:15] = 5'($urandom_range(0, 7));
    s.inst[24:20] = 5'($urandom_range(0, 7));
    s.v    = ($urandom_range(0, 3) != 0);
    s.pc   = $urandom & ~32'h3;
    s.r1   = pickval();
    s.r2   = pickval();
    s.exop = ($urandom_range(0, 1) == 1) ? LOAD : ops[$urandom_range(0, 11)];
    s.exw  = 1'($urandom_range(0, 1));
    s.exwd = 5'($urandom_range(0, 7));
    s.exd  = pickval();
    s.mw   = 1'($urandom_range(0, 1));
    s.mwd  = 5'($urandom_range(0, 7));
    s.md   = pickval();
    s.rdy  = ($urandom_range(0, 3) != 0);
    s.fl   = ($urandom_range(0, 15) == 0);
    return s;
  endfunction

  task automatic apply(input stim_t s);
    if_valid_i = s.v; inst_i = s.inst; pc_i = s.pc; reg1_data_i = s.r1; reg2_data_i = s.r2;
    ex_op_i = s.exop; ex_wreg_i = s.exw; ex_wd_i = s.exwd; ex_wdata_i = s.exd;
    mem_wreg_i = s.mw; mem_wd_i = s.mwd; mem_wdata_i = s.md; flush_i = s.fl; ex_ready_i = s.rdy;
  endtask

  // One clock of stimulus: drive, predict this cycle's status and any issued payload, advance model.
  task automatic step(input stim_t s);
    logic [6:0] op; logic [4:0] a1, a2; logic [2:0] f3;
    logic legal, u1, u2, haz, rdy, acc, take, nv;
    logic [31:0] v1, v2, imm, tgt;
    stat_t st; pay_t p;
    @(posedge clk); #1;
    // flush only when any held entry is being consumed, so every issued payload reaches EX
    if (s.fl && m_valid && !s.rdy) s.fl = 1'b0;
    apply(s);
    op = s.inst[6:0]; a1 = s.inst[19:15]; a2 = s.inst[24:20]; f3 = s.inst[14:12];
    legal = op inside {LUI, AUIPC, LOAD, STORE, OPIMM, OP, BR, JAL, JALR};
    u1  = op inside {LOAD, STORE, OPIMM, OP, BR, JALR};
    u2  = op inside {STORE, OP, BR};
    haz = m_valid && s.exop == LOAD && s.exw && s.exwd != 0 &&
          ((u1 && s.exwd == a1) || (u2 && s.exwd == a2));
    rdy = !haz && (!m_valid || s.rdy);
    acc = s.v && rdy && !m_bflag;
    st.rdy = rdy; st.valid = m_valid; st.bflag = m_bflag; st.baddr = m_baddr;
    st.cnt = CNT_W'(m_cnt); st.a1 = a1; st.a2 = a2;
    sq.push_back(st);
    v1 = opnd(a1, u1, s.r1, s);
    v2 = opnd(a2, u2, s.r2, s);
    imm = imm_of(s.inst);
    if (acc && !s.fl) begin
      p.pc = s.pc; p.r1 = v1; p.r2 = v2; p.imm = imm; p.op = op; p.f3 = f3; p.f7 = s.inst[30];
      p.wd = s.inst[11:7]; p.wreg = legal && !(op inside {STORE, BR}); p.ill = !legal;
      pq.push_back(p);
    end
    take = 1'b0; tgt = s.pc + imm;
    if (op == BR) take = br_taken(f3, v1, v2);
    else if (op == JAL) take = 1'b1;
    else if (op == JALR) begin take = 1'b1; tgt = (v1 + imm) & ~32'h1; end
    if (s.fl) nv = 1'b0;
    else if (acc) nv = 1'b1;
    else if (s.rdy) nv = 1'b0;
    else nv = m_valid;
    if (haz && s.rdy && !s.fl && m_cnt < CNT_MAX) m_cnt++;
    if (BR_EN && acc && !s.fl && take) begin m_bflag = 1'b1; m_baddr = tgt; end
    else m_bflag = 1'b0;
    m_valid = nv;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", ex_valid_o, 0);
    chk("rst_data", pc_o | reg1_o | reg2_o | imm_o | branch_address_o, 0);
    chk("rst_ctrl", {op_o, funct3_o, funct7_o, wd_o, wreg_o, illegal_o, branch_flag_o, bubble_cnt_o}, 0);
    sq.delete(); pq.delete();
    m_valid = 1'b0; m_bflag = 1'b0; m_baddr = '0; m_cnt = 0;
    apply(idle());
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  stat_t me;
  pay_t  mp;
  always @(negedge clk) begin
    if (!rst && sq.size() > 0) begin
      me = sq.pop_front();
      chk("id_ready", id_ready_o, me.rdy);
      chk("ex_valid", ex_valid_o, me.valid);
      chk("branch_flag", branch_flag_o, me.bflag);
      if (me.bflag) chk("branch_addr", branch_address_o, me.baddr);
      chk("bubble_cnt", bubble_cnt_o, me.cnt);
      chk("reg_addr", {reg1_addr_o, reg2_addr_o}, {me.a1, me.a2});
      if (ex_valid_o && ex_ready_i) begin
        chk("payload_queued", 64'(pq.size() > 0), 1);
        if (pq.size() > 0) begin
          mp = pq.pop_front();
          chk("pc", pc_o, mp.pc);
          chk("reg1", reg1_o, mp.r1);
          chk("reg2", reg2_o, mp.r2);
          chk("imm", imm_o, mp.imm);
          chk("op_f3_f7", {op_o, funct3_o, funct7_o}, {mp.op, mp.f3, mp.f7});
          chk("wd_wreg_ill", {wd_o, wreg_o, illegal_o}, {mp.wd, mp.wreg, mp.ill});
        end
      end
    end
  end

  initial begin
    stim_t s;
    apply(idle());
    repeat (2) @(posedge clk);
    do_reset();

    // reset while a held instruction sits in ID/EX
    s = idle(); s.v = 1'b1; s.inst = enc_i(OPIMM, 5'd9, 3'd0, 5'd0, 12'd33); s.rdy = 1'b0; step(s);
    s = idle(); s.rdy = 1'b0; step(s);
    #2; do_reset();

    // ADDI x1,x0,5 after reset
    s = idle(); s.v = 1'b1; s.inst = enc_i(OPIMM, 5'd1, 3'd0, 5'd0, 12'd5); s.r1 = 32'h77; step(s);
    s = idle(); s.rdy = 1'b0; step(s);
    chk("addi_fields", {imm_o, reg1_o, 27'b0, wd_o}, {32'd5, 32'd0, 32'd1});

    // load-use: LW x3 in EX, ADD x4,x3,x2 in ID
    s = idle(); s.v = 1'b1; s.inst = enc_i(LOAD, 5'd3, 3'd2, 5'd1, 12'd0); step(s);
    s = idle(); s.v = 1'b1; s.inst = enc_r(7'h00, 5'd2, 5'd3, 5'd4); s.r1 = 32'h5; s.r2 = 32'h6;
    s.exop = LOAD; s.exw = 1'b1; s.exwd = 5'd3; s.exd = 32'hDEAD; step(s);
    s.exop = OP; s.exw = 1'b0; s.mw = 1'b1; s.mwd = 5'd3; s.md = 32'h1234; step(s);
    s = idle(); s.rdy = 1'b0; step(s);
    chk("loaduse_mem_fwd", reg1_o, 32'h1234);

    // EX beats MEM; x0 never forwarded
    s = idle(); s.v = 1'b1; s.inst = enc_r(7'h20, 5'd5, 5'd5, 5'd6); s.r1 = 32'h11; s.r2 = 32'h11;
    s.exop = OP; s.exw = 1'b1; s.exwd = 5'd5; s.exd = 32'hAA; s.mw = 1'b1; s.mwd = 5'd5; s.md = 32'hBB;
    step(s);
    s = idle(); s.v = 1'b1; s.inst = enc_r(7'h00, 5'd0, 5'd0, 5'd7); s.r1 = 32'h99; s.r2 = 32'h99;
    s.exw = 1'b1; s.exwd = 5'd0; s.exd = 32'h55; step(s);
    chk("fwd_ex_over_mem", {reg1_o, reg2_o}, {32'hAA, 32'hAA});
    s = idle(); step(s);
    chk("x0_not_fwd", {reg1_o, reg2_o}, 64'h0);

    // BEQ taken at 0x100, wrong-path input dropped; BGE with equal operands
    s = idle(); s.v = 1'b1; s.inst = enc_b(3'd0, 5'd1, 5'd2, -13'sd8); s.pc = 32'h100;
    s.r1 = 32'h7; s.r2 = 32'h7; step(s);
    s = idle(); s.v = 1'b1; s.inst = enc_i(OPIMM, 5'd9, 3'd0, 5'd0, 12'd1); s.pc = 32'h104; step(s);
    s = idle(); s.v = 1'b1; s.inst = enc_b(3'd5, 5'd1, 5'd2, 13'd16); s.pc = 32'h200;
    s.r1 = 32'hFFFF_FFF0; s.r2 = 32'hFFFF_FFF0; step(s);
    s = idle(); step(s);

    // JALR rs1=0x1003, then JAL killed by flush in its accept cycle
    s = idle(); s.v = 1'b1; s.inst = enc_i(JALR, 5'd1, 3'd0, 5'd1, 12'd0); s.r1 = 32'h1003; step(s);
    s = idle(); step(s);
    s = idle(); s.v = 1'b1; s.inst = 32'h0080_00EF; s.pc = 32'h300; s.fl = 1'b1; step(s);
    s = idle(); step(s);

    // EX stalled for 3 cycles with a valid entry held
    s = idle(); s.v = 1'b1; s.inst = enc_i(OPIMM, 5'd2, 3'd0, 5'd0, 12'd7); step(s);
    for (int k = 0; k < 3; k++) begin
      s = idle(); s.v = 1'b1; s.inst = enc_i(OPIMM, 5'd3, 3'd0, 5'd0, 12'd8); s.rdy = 1'b0; step(s);
    end
    s.rdy = 1'b1; step(s);

    // saturate the bubble counter
    for (int k = 0; k < 5; k++) begin
      s = idle(); s.v = 1'b1; s.inst = enc_i(OPIMM, 5'd1, 3'd0, 5'd0, 12'd1); step(s);
      s = idle(); s.v = 1'b1; s.inst = enc_r(7'h00, 5'd2, 5'd3, 5'd4);
      s.exop = LOAD; s.exw = 1'b1; s.exwd = 5'd3; step(s);
    end
    s = idle(); step(s);
    chk("bubble_sat", bubble_cnt_o, CNT_MAX);

    // reset in the cycle a redirect is showing
    s = idle(); s.v = 1'b1; s.inst = 32'h0080_00EF; s.pc = 32'h400; step(s);
    s = idle(); step(s);
    #2; do_reset();

    for (int k = 0; k < 1500; k++) step(rnd());

    repeat (4) step(idle());
    @(negedge clk); #1;
    chk("drain_empty", 64'(pq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
